ycbcr_seg_stats: RTL and testbench
==================================

Name: ycbcr_seg_stats

Overview:
- Parametrised successor of the camera-path RGB→YCbCr converter. Accepts RGB565 or RGB888 pixels selected by parameter.
- Produces rounded, saturated BT.601 full-range Y/Cb/Cr and a binary colour-segmentation mask from runtime Cb/Cr/Y windows.
- Accumulates per-frame hit count and bounding box for the ball-tracking logic downstream.
- Sits between the camera capture/frame buffer read side and the display/overlay and target-tracking blocks.

Parameters:
IN_FMT, 0, input format: 0 = RGB565 on img_rgb[15:0], 1 = RGB888 on img_rgb[23:0]
X_W, 12, column counter width
Y_W, 11, row counter width

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
pre_frame_vsync  in  1  frame sync, active-high
pre_frame_hsync  in  1  line sync, active-high
pre_frame_de  in  1  pixel valid
img_rgb  in  24  pixel; RGB565 uses [15:0] as {R5,G6,B5}; RGB888 uses {R8,G8,B8}
thr_y_min  in  8  minimum Y for a hit
thr_cb_lo / thr_cb_hi  in  8 each  inclusive Cb window
thr_cr_lo / thr_cr_hi  in  8 each  inclusive Cr window
post_frame_vsync / post_frame_hsync / post_frame_de  out  1 each  syncs delayed to match data
img_y / img_cb / img_cr  out  8 each  converted pixel
mask  out  1  segmentation result
stats_valid  out  1  one-cycle pulse: the stats outputs hold a completed frame
hit_cnt  out  X_W+Y_W  hits in the last frame
found  out  1  hit_cnt != 0
box_xmin / box_xmax  out  X_W each  bounding box columns
box_ymin / box_ymax  out  Y_W each  bounding box rows

Behaviour:
- Reset: every register and output clears to 0, including the pipeline, counters, stats and the armed flag.
- Expansion to RGB888 (IN_FMT=0) by MSB replication: R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
- Arithmetic, 8-bit coefficients, signed 18-bit intermediates:
  - Y = (77R+150G+29B+128)>>8
  - Cb = (−43R−85G+128B+32768+128)>>8
  - Cr = (128R−107G−21B+32768+128)>>8
  - Saturate each result to 0..255.
- Pipeline, fixed latency 3 cycles, no backpressure:
  - S1: products.
  - S2: sums plus offsets.
  - S3: round/saturate, plus mask compare against the latched thresholds.
- vsync/hsync/de pass through a 3-deep delay line.
- img_y/img_cb/img_cr/mask are forced to 0 when post_frame_de=0.
- mask = post_frame_de & (Y ≥ y_min) & (cb_lo ≤ Cb ≤ cb_hi) & (cr_lo ≤ Cr ≤ cr_hi), using the latched thresholds.
- Threshold latch: all thr_* inputs are captured on the rising edge of pre_frame_vsync and held for the whole frame. Mid-frame changes have no effect until the next frame.
- Coordinates are kept on the post_ side:
  - x increments per post_frame_de cycle and clears on the de falling edge.
  - y increments on the de falling edge and clears on the post_frame_vsync rising edge.
- Accumulators (hit count, min x, max x, min y, max y):
  - Initialise to cnt=0, min=all-ones, max=0.
  - Update on every mask=1 cycle.
  - hit count saturates at all-ones.
- Frame end, on the post_frame_vsync rising edge:
  - If armed: copy the accumulators to the outputs, pulse stats_valid for 1 cycle, and set found = (cnt≠0).
  - If cnt=0: box outputs are 0.
  - Accumulators then reinitialise.
  - armed sets on the first post vsync rising edge after reset. This means no stats_valid is issued for a partial frame after reset.
- A mask hit coinciding with the vsync edge cannot occur (de=0 at that time). If it does, it counts toward the new frame.
- Stats outputs hold their values until the next stats_valid.

Decomposition:
- Package ycbcr_pkg holds:
  - coefficient constants (77, 150, 29, 43, 85, 128, 107, 21)
  - offsets 32768 and 128
  - IN_FMT encodings
  - a saturate-to-8-bit function
- Sub-module rgb2ycbcr_pipe holds the conversion pipeline: 3 stages with the sync delay line.
- The top holds threshold latching, the mask, coordinate counters and frame stats.

Test Plan:
- IN_FMT=0, single pixel 0xFFFF → after 3 cycles Y=255 Cb=128 Cr=128; pixel 0x0000 → Y=0 Cb=128 Cr=128.
- Saturation: 0xF800 → Y=77 Cb=85 Cr=255 (raw 256 clipped); 0x001F → Y=29 Cb=255 Cr=107.
- Mask: thresholds cb 0x30..0x80, cr 0xC8..0xFF, y_min 0 → 0xF800 gives mask=1, 0x07E0 gives mask=0. Equality at cb_lo/cb_hi gives a hit.
- Stats, 4x4 frame after one prior frame: red at (x1,y2) and (x3,y0), rest black → next vsync: stats_valid=1 for 1 cycle, hit_cnt=2, xmin=1, xmax=3, ymin=0, ymax=2, found=1. An all-black frame gives hit_cnt=0, found=0, box=0.
- Threshold change mid-frame → mask for the rest of that frame uses the old window; the new window applies from the next vsync.
- rst asserted mid-frame → all outputs 0 immediately. The first post-reset vsync produces no stats_valid; the following one does.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared constants and helpers for the RGB to YCbCr segmentation path.
// BT.601 full-range coefficients are scaled by 256 so that results fit 8-bit fixed point.
package ycbcr_pkg;

  localparam logic [7:0] CoefYR  = 8'd77;
  localparam logic [7:0] CoefYG  = 8'd150;
  localparam logic [7:0] CoefYB  = 8'd29;
  localparam logic [7:0] CoefCbR = 8'd43;
  localparam logic [7:0] CoefCbG = 8'd85;
  localparam logic [7:0] CoefCbB = 8'd128;
  localparam logic [7:0] CoefCrR = 8'd128;
  localparam logic [7:0] CoefCrG = 8'd107;
  localparam logic [7:0] CoefCrB = 8'd21;

  localparam logic [17:0] OffChroma = 18'd32768;
  localparam logic [17:0] OffRound  = 18'd128;

  localparam int unsigned FmtRgb565 = 0;
  localparam int unsigned FmtRgb888 = 1;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } sync_t;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] c);
    return {8'h00, a} * {8'h00, c};
  endfunction

  // Takes bits [17:8] of a two's-complement 18-bit sum and clips the integer part to 0..255.
  function automatic logic [7:0] sat8(input logic [9:0] int_part);
    if (int_part[9]) begin
      return 8'h00;
    end else if (int_part[8]) begin
      return 8'hff;
    end
    return int_part[7:0];
  endfunction

endpackage

// File: rtl/rgb2ycbcr_pipe.sv
// Three-stage RGB to YCbCr converter: products, offset sums, round/saturate.
// Syncs travel through a matching delay line; pixel outputs are zero outside de.
module rgb2ycbcr_pipe
  import ycbcr_pkg::*;
#(
  parameter int unsigned IN_FMT = FmtRgb565
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vsync,
  input  logic        in_hsync,
  input  logic        in_de,
  input  logic [23:0] rgb,
  output logic        out_vsync,
  output logic        out_hsync,
  output logic        out_de,
  output logic [7:0]  y,
  output logic [7:0]  cb,
  output logic [7:0]  cr
);

  logic [7:0] r, g, b;
  logic       unused_rgb_hi;

  // RGB565 widens by repeating the MSBs so that full scale maps to 255.
  always_comb begin
    if (IN_FMT == FmtRgb565) begin
      r = {rgb[15:11], rgb[15:13]};
      g = {rgb[10:5], rgb[10:9]};
      b = {rgb[4:0], rgb[4:2]};
    end else begin
      r = rgb[23:16];
      g = rgb[15:8];
      b = rgb[7:0];
    end
  end

  assign unused_rgb_hi = ^rgb[23:16];

  // Stage 1: products
  sync_t       sync1_q;
  logic [15:0] p_yr_q, p_yg_q, p_yb_q;
  logic [15:0] p_cbr_q, p_cbg_q, p_cbb_q;
  logic [15:0] p_crr_q, p_crg_q, p_crb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      p_yr_q  <= '0;
      p_yg_q  <= '0;
      p_yb_q  <= '0;
      p_cbr_q <= '0;
      p_cbg_q <= '0;
      p_cbb_q <= '0;
      p_crr_q <= '0;
      p_crg_q <= '0;
      p_crb_q <= '0;
    end else begin
      sync1_q <= '{vsync: in_vsync, hsync: in_hsync, de: in_de};
      p_yr_q  <= mul8(r, CoefYR);
      p_yg_q  <= mul8(g, CoefYG);
      p_yb_q  <= mul8(b, CoefYB);
      p_cbr_q <= mul8(r, CoefCbR);
      p_cbg_q <= mul8(g, CoefCbG);
      p_cbb_q <= mul8(b, CoefCbB);
      p_crr_q <= mul8(r, CoefCrR);
      p_crg_q <= mul8(g, CoefCrG);
      p_crb_q <= mul8(b, CoefCrB);
    end
  end

  // Stage 2: signed sums in 18-bit two's complement, rounding offset folded in
  sync_t       sync2_q;
  logic [17:0] sum_y_d, sum_cb_d, sum_cr_d;
  logic [17:0] sum_y_q, sum_cb_q, sum_cr_q;

  always_comb begin
    sum_y_d  = {2'b00, p_yr_q} + {2'b00, p_yg_q} + {2'b00, p_yb_q} + OffRound;
    sum_cb_d = {2'b00, p_cbb_q} - {2'b00, p_cbr_q} - {2'b00, p_cbg_q} + OffChroma + OffRound;
    sum_cr_d = {2'b00, p_crr_q} - {2'b00, p_crg_q} - {2'b00, p_crb_q} + OffChroma + OffRound;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync2_q  <= '0;
      sum_y_q  <= '0;
      sum_cb_q <= '0;
      sum_cr_q <= '0;
    end else begin
      sync2_q  <= sync1_q;
      sum_y_q  <= sum_y_d;
      sum_cb_q <= sum_cb_d;
      sum_cr_q <= sum_cr_d;
    end
  end

  // Stage 3: truncate the rounded sum and clip
  sync_t      sync3_q;
  logic [7:0] y_q, cb_q, cr_q;
  logic       unused_frac;

  assign unused_frac = ^{sum_y_q[7:0], sum_cb_q[7:0], sum_cr_q[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync3_q <= '0;
      y_q     <= '0;
      cb_q    <= '0;
      cr_q    <= '0;
    end else begin
      sync3_q <= sync2_q;
      y_q     <= sync2_q.de ? sat8(sum_y_q[17:8])  : 8'h00;
      cb_q    <= sync2_q.de ? sat8(sum_cb_q[17:8]) : 8'h00;
      cr_q    <= sync2_q.de ? sat8(sum_cr_q[17:8]) : 8'h00;
    end
  end

  assign out_vsync = sync3_q.vsync;
  assign out_hsync = sync3_q.hsync;
  assign out_de    = sync3_q.de;
  assign y         = y_q;
  assign cb        = cb_q;
  assign cr        = cr_q;

endmodule

// File: rtl/ycbcr_seg_stats.sv
// Colour segmentation on converted pixels with per-frame hit count and bounding box.
// Thresholds are frozen per frame; stats publish on the output-side vsync rising edge.
module ycbcr_seg_stats
  import ycbcr_pkg::*;
#(
  parameter int unsigned IN_FMT = FmtRgb565,
  parameter int unsigned X_W    = 12,
  parameter int unsigned Y_W    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pre_frame_vsync,
  input  logic               pre_frame_hsync,
  input  logic               pre_frame_de,
  input  logic [23:0]        img_rgb,
  input  logic [7:0]         thr_y_min,
  input  logic [7:0]         thr_cb_lo,
  input  logic [7:0]         thr_cb_hi,
  input  logic [7:0]         thr_cr_lo,
  input  logic [7:0]         thr_cr_hi,
  output logic               post_frame_vsync,
  output logic               post_frame_hsync,
  output logic               post_frame_de,
  output logic [7:0]         img_y,
  output logic [7:0]         img_cb,
  output logic [7:0]         img_cr,
  output logic               mask,
  output logic               stats_valid,
  output logic [X_W+Y_W-1:0] hit_cnt,
  output logic               found,
  output logic [X_W-1:0]     box_xmin,
  output logic [X_W-1:0]     box_xmax,
  output logic [Y_W-1:0]     box_ymin,
  output logic [Y_W-1:0]     box_ymax
);

  localparam int unsigned CntW = X_W + Y_W;

  rgb2ycbcr_pipe #(
    .IN_FMT(IN_FMT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vsync (pre_frame_vsync),
    .in_hsync (pre_frame_hsync),
    .in_de    (pre_frame_de),
    .rgb      (img_rgb),
    .out_vsync(post_frame_vsync),
    .out_hsync(post_frame_hsync),
    .out_de   (post_frame_de),
    .y        (img_y),
    .cb       (img_cb),
    .cr       (img_cr)
  );

  // Threshold latch on the input-side frame start
  logic       pre_vsync_q;
  logic [7:0] thr_y_min_q, thr_cb_lo_q, thr_cb_hi_q, thr_cr_lo_q, thr_cr_hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_vsync_q <= 1'b0;
      thr_y_min_q <= '0;
      thr_cb_lo_q <= '0;
      thr_cb_hi_q <= '0;
      thr_cr_lo_q <= '0;
      thr_cr_hi_q <= '0;
    end else begin
      pre_vsync_q <= pre_frame_vsync;
      if (pre_frame_vsync && !pre_vsync_q) begin
        thr_y_min_q <= thr_y_min;
        thr_cb_lo_q <= thr_cb_lo;
        thr_cb_hi_q <= thr_cb_hi;
        thr_cr_lo_q <= thr_cr_lo;
        thr_cr_hi_q <= thr_cr_hi;
      end
    end
  end

  assign mask = post_frame_de
              & (img_y >= thr_y_min_q)
              & (img_cb >= thr_cb_lo_q) & (img_cb <= thr_cb_hi_q)
              & (img_cr >= thr_cr_lo_q) & (img_cr <= thr_cr_hi_q);

  // Output-side edge detection and pixel coordinates
  logic           post_vsync_q, post_de_q;
  logic           vs_rise, de_fall;
  logic [X_W-1:0] x_d, x_q;
  logic [Y_W-1:0] y_d, y_q;

  assign vs_rise = post_frame_vsync & ~post_vsync_q;
  assign de_fall = post_de_q & ~post_frame_de;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (post_frame_de) begin
      x_d = x_q + X_W'(1);
    end else if (de_fall) begin
      x_d = '0;
    end
    if (de_fall) begin
      y_d = y_q + Y_W'(1);
    end
    if (vs_rise) begin
      y_d = '0;
    end
  end

  // Accumulators; a hit on the vsync edge itself lands in the new frame
  logic [CntW-1:0] acc_cnt_d, acc_cnt_q;
  logic [X_W-1:0]  acc_xmin_d, acc_xmin_q, acc_xmax_d, acc_xmax_q;
  logic [Y_W-1:0]  acc_ymin_d, acc_ymin_q, acc_ymax_d, acc_ymax_q;

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_xmin_d = acc_xmin_q;
    acc_xmax_d = acc_xmax_q;
    acc_ymin_d = acc_ymin_q;
    acc_ymax_d = acc_ymax_q;
    if (vs_rise) begin
      acc_cnt_d  = '0;
      acc_xmin_d = '1;
      acc_xmax_d = '0;
      acc_ymin_d = '1;
      acc_ymax_d = '0;
    end
    if (mask) begin
      if (acc_cnt_d != '1) begin
        acc_cnt_d = acc_cnt_d + CntW'(1);
      end
      if (x_q < acc_xmin_d) acc_xmin_d = x_q;
      if (x_q > acc_xmax_d) acc_xmax_d = x_q;
      if (y_q < acc_ymin_d) acc_ymin_d = y_q;
      if (y_q > acc_ymax_d) acc_ymax_d = y_q;
    end
  end

  // Published stats; armed suppresses the partial frame seen right after reset
  logic            armed_d, armed_q;
  logic            stats_valid_d, stats_valid_q;
  logic            found_d, found_q;
  logic [CntW-1:0] hit_cnt_d, hit_cnt_q;
  logic [X_W-1:0]  box_xmin_d, box_xmin_q, box_xmax_d, box_xmax_q;
  logic [Y_W-1:0]  box_ymin_d, box_ymin_q, box_ymax_d, box_ymax_q;

  always_comb begin
    armed_d       = armed_q | vs_rise;
    stats_valid_d = 1'b0;
    found_d       = found_q;
    hit_cnt_d     = hit_cnt_q;
    box_xmin_d    = box_xmin_q;
    box_xmax_d    = box_xmax_q;
    box_ymin_d    = box_ymin_q;
    box_ymax_d    = box_ymax_q;
    if (vs_rise && armed_q) begin
      stats_valid_d = 1'b1;
      hit_cnt_d     = acc_cnt_q;
      found_d       = (acc_cnt_q != '0);
      if (acc_cnt_q != '0) begin
        box_xmin_d = acc_xmin_q;
        box_xmax_d = acc_xmax_q;
        box_ymin_d = acc_ymin_q;
        box_ymax_d = acc_ymax_q;
      end else begin
        box_xmin_d = '0;
        box_xmax_d = '0;
        box_ymin_d = '0;
        box_ymax_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vsync_q  <= 1'b0;
      post_de_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      acc_cnt_q     <= '0;
      acc_xmin_q    <= '0;
      acc_xmax_q    <= '0;
      acc_ymin_q    <= '0;
      acc_ymax_q    <= '0;
      armed_q       <= 1'b0;
      stats_valid_q <= 1'b0;
      found_q       <= 1'b0;
      hit_cnt_q     <= '0;
      box_xmin_q    <= '0;
      box_xmax_q    <= '0;
      box_ymin_q    <= '0;
      box_ymax_q    <= '0;
    end else begin
      post_vsync_q  <= post_frame_vsync;
      post_de_q     <= post_frame_de;
      x_q           <= x_d;
      y_q           <= y_d;
      acc_cnt_q     <= acc_cnt_d;
      acc_xmin_q    <= acc_xmin_d;
      acc_xmax_q    <= acc_xmax_d;
      acc_ymin_q    <= acc_ymin_d;
      acc_ymax_q    <= acc_ymax_d;
      armed_q       <= armed_d;
      stats_valid_q <= stats_valid_d;
      found_q       <= found_d;
      hit_cnt_q     <= hit_cnt_d;
      box_xmin_q    <= box_xmin_d;
      box_xmax_q    <= box_xmax_d;
      box_ymin_q    <= box_ymin_d;
      box_ymax_q    <= box_ymax_d;
    end
  end

  assign stats_valid = stats_valid_q;
  assign found       = found_q;
  assign hit_cnt     = hit_cnt_q;
  assign box_xmin    = box_xmin_q;
  assign box_xmax    = box_xmax_q;
  assign box_ymin    = box_ymin_q;
  assign box_ymax    = box_ymax_q;

endmodule

// File: tb/tb_ycbcr_seg_stats.sv
// Directed bench for ycbcr_seg_stats (RGB565 input): conversion, mask windows,
// frame stats, threshold freezing and mid-frame reset.
module tb_ycbcr_seg_stats;

  localparam int unsigned XW = 12;
  localparam int unsigned YW = 11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pre_frame_vsync = 1'b0;
  logic           pre_frame_hsync = 1'b0;
  logic           pre_frame_de = 1'b0;
  logic [23:0]    img_rgb = '0;
  logic [7:0]     thr_y_min = '0, thr_cb_lo = '0, thr_cb_hi = '0, thr_cr_lo = '0, thr_cr_hi = '0;
  logic           post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [7:0]     img_y, img_cb, img_cr;
  logic           mask, stats_valid, found;
  logic [XW+YW-1:0] hit_cnt;
  logic [XW-1:0]  box_xmin, box_xmax;
  logic [YW-1:0]  box_ymin, box_ymax;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ycbcr_seg_stats #(
    .IN_FMT(0),
    .X_W   (XW),
    .Y_W   (YW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_hsync (pre_frame_hsync),
    .pre_frame_de    (pre_frame_de),
    .img_rgb         (img_rgb),
    .thr_y_min       (thr_y_min),
    .thr_cb_lo       (thr_cb_lo),
    .thr_cb_hi       (thr_cb_hi),
    .thr_cr_lo       (thr_cr_lo),
    .thr_cr_hi       (thr_cr_hi),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_hsync(post_frame_hsync),
    .post_frame_de   (post_frame_de),
    .img_y           (img_y),
    .img_cb          (img_cb),
    .img_cr          (img_cr),
    .mask            (mask),
    .stats_valid     (stats_valid),
    .hit_cnt         (hit_cnt),
    .found           (found),
    .box_xmin        (box_xmin),
    .box_xmax        (box_xmax),
    .box_ymin        (box_ymin),
    .box_ymax        (box_ymax)
  );

  // Pixel table: white, black, red, blue, green, mid grey, mixed bits
  localparam logic [0:6][15:0] ConvPix = {16'hFFFF, 16'h0000, 16'hF800, 16'h001F, 16'h07E0,
                                          16'h8410, 16'h4A69};
  localparam logic [0:6][7:0]  ConvY   = {8'd255, 8'd0, 8'd77, 8'd29, 8'd149, 8'd131, 8'd76};
  localparam logic [0:6][7:0]  ConvCb  = {8'd128, 8'd128, 8'd85, 8'd255, 8'd43, 8'd129, 8'd127};
  localparam logic [0:6][7:0]  ConvCr  = {8'd128, 8'd128, 8'd255, 8'd107, 8'd21, 8'd129, 8'd127};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-pixel line; returns with that pixel on the post_ side
  task automatic send_pixel(input logic [15:0] pix);
    pre_frame_de = 1'b1;
    img_rgb = {8'h00, pix};
    tick();
    pre_frame_de = 1'b0;
    img_rgb = '0;
    tick();
    tick();
  endtask

  task automatic set_thr(input logic [7:0] ymin, input logic [7:0] cblo, input logic [7:0] cbhi,
                         input logic [7:0] crlo, input logic [7:0] crhi);
    thr_y_min = ymin;
    thr_cb_lo = cblo;
    thr_cb_hi = cbhi;
    thr_cr_lo = crlo;
    thr_cr_hi = crhi;
  endtask

  // Two-cycle vsync pulse; counts sampled stats_valid cycles over a bounded window
  task automatic do_vsync(output int valid_cycles);
    valid_cycles = 0;
    pre_frame_vsync = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) pre_frame_vsync = 1'b0;
      tick();
      if (stats_valid === 1'b1) valid_cycles++;
    end
  endtask

  // 4x4 frame; optional red hits at (1,2) and (3,0), everything else black
  task automatic send_frame(input bit with_hits);
    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 4; xx++) begin
        pre_frame_de = 1'b1;
        img_rgb = (with_hits && ((xx == 1 && yy == 2) || (xx == 3 && yy == 0))) ?
                  24'h00F800 : 24'h000000;
        tick();
      end
      pre_frame_de = 1'b0;
      img_rgb = '0;
      pre_frame_hsync = 1'b1;
      tick();
      pre_frame_hsync = 1'b0;
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({post_frame_vsync, post_frame_hsync, post_frame_de, mask, stats_valid, found} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000000",
               {post_frame_vsync, post_frame_hsync, post_frame_de, mask, stats_valid, found});
    end
    checks++;
    if ({img_y, img_cb, img_cr} !== 24'h0) begin
      failures++;
      $display("FAIL reset_pixel: got %h expected 000000", {img_y, img_cb, img_cr});
    end
    checks++;
    if ({hit_cnt, box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      failures++;
      $display("FAIL reset_stats: got cnt=%0d box=%0d,%0d,%0d,%0d expected all 0",
               hit_cnt, box_xmin, box_xmax, box_ymin, box_ymax);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_convert();
    // Sync delay line: hsync travels with the pixel
    pre_frame_hsync = 1'b1;
    send_pixel(16'hFFFF);
    pre_frame_hsync = 1'b0;
    checks++;
    if ({post_frame_hsync, post_frame_de} !== 2'b11) begin
      failures++;
      $display("FAIL sync_delay: got hsync,de=%b expected 11", {post_frame_hsync, post_frame_de});
    end
    tick();
    checks++;
    if ({post_frame_de, img_y, img_cb, img_cr} !== 25'h0) begin
      failures++;
      $display("FAIL blank_zero: got de=%b y=%0d cb=%0d cr=%0d expected all 0",
               post_frame_de, img_y, img_cb, img_cr);
    end
    for (int i = 0; i < 7; i++) begin
      send_pixel(ConvPix[i]);
      checks++;
      if (img_y !== ConvY[i]) begin
        failures++;
        $display("FAIL conv_y[%h]: got %0d expected %0d", ConvPix[i], img_y, ConvY[i]);
      end
      checks++;
      if (img_cb !== ConvCb[i]) begin
        failures++;
        $display("FAIL conv_cb[%h]: got %0d expected %0d", ConvPix[i], img_cb, ConvCb[i]);
      end
      checks++;
      if (img_cr !== ConvCr[i]) begin
        failures++;
        $display("FAIL conv_cr[%h]: got %0d expected %0d", ConvPix[i], img_cr, ConvCr[i]);
      end
    end
  endtask

  task automatic test_mask();
    int n;
    set_thr(8'd0, 8'h30, 8'h80, 8'hC8, 8'hFF);
    do_vsync(n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL first_vsync_no_stats: got %0d valid cycles expected 0", n);
    end
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b1) begin
      failures++;
      $display("FAIL mask_red: got %b expected 1", mask);
    end
    send_pixel(16'h07E0);
    checks++;
    if (mask !== 1'b0) begin
      failures++;
      $display("FAIL mask_green: got %b expected 0", mask);
    end
    // Cb window collapsed onto red's Cb, Y floor equal to red's Y
    set_thr(8'd77, 8'h55, 8'h55, 8'hC8, 8'hFF);
    do_vsync(n);
    checks++;
    if (n !== 1 || hit_cnt !== 1 || found !== 1'b1) begin
      failures++;
      $display("FAIL mask_frame_stats: got valid=%0d cnt=%0d found=%b expected 1 1 1",
               n, hit_cnt, found);
    end
    checks++;
    if ({box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      failures++;
      $display("FAIL mask_frame_box: got %0d,%0d,%0d,%0d expected 0,0,0,0",
               box_xmin, box_xmax, box_ymin, box_ymax);
    end
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b1) begin
      failures++;
      $display("FAIL mask_edge_equal: got %b expected 1", mask);
    end
    set_thr(8'd0, 8'h56, 8'h80, 8'hC8, 8'hFF);
    do_vsync(n);
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b0) begin
      failures++;
      $display("FAIL mask_cb_below_lo: got %b expected 0", mask);
    end
    set_thr(8'd78, 8'h30, 8'h80, 8'hC8, 8'hFF);
    do_vsync(n);
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b0) begin
      failures++;
      $display("FAIL mask_y_below_min: got %b expected 0", mask);
    end
  endtask

  task automatic test_stats();
    int n;
    set_thr(8'd0, 8'h30, 8'h80, 8'hC8, 8'hFF);
    do_vsync(n);
    send_frame(1'b1);
    do_vsync(n);
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL stats_pulse: got %0d valid cycles expected 1", n);
    end
    checks++;
    if (hit_cnt !== 2 || found !== 1'b1) begin
      failures++;
      $display("FAIL stats_count: got cnt=%0d found=%b expected 2 1", hit_cnt, found);
    end
    checks++;
    if (box_xmin !== 1 || box_xmax !== 3 || box_ymin !== 0 || box_ymax !== 2) begin
      failures++;
      $display("FAIL stats_box: got x %0d..%0d y %0d..%0d expected x 1..3 y 0..2",
               box_xmin, box_xmax, box_ymin, box_ymax);
    end
    send_frame(1'b0);
    checks++;
    if (hit_cnt !== 2 || box_xmax !== 3 || found !== 1'b1) begin
      failures++;
      $display("FAIL stats_hold: got cnt=%0d xmax=%0d found=%b expected 2 3 1",
               hit_cnt, box_xmax, found);
    end
    do_vsync(n);
    checks++;
    if (n !== 1 || hit_cnt !== 0 || found !== 1'b0) begin
      failures++;
      $display("FAIL stats_black: got valid=%0d cnt=%0d found=%b expected 1 0 0",
               n, hit_cnt, found);
    end
    checks++;
    if ({box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      failures++;
      $display("FAIL stats_black_box: got %0d,%0d,%0d,%0d expected 0,0,0,0",
               box_xmin, box_xmax, box_ymin, box_ymax);
    end
  endtask

  task automatic test_thr_midframe();
    int n;
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b1) begin
      failures++;
      $display("FAIL thr_old_before: got %b expected 1", mask);
    end
    set_thr(8'd0, 8'h20, 8'h30, 8'h10, 8'h20);
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b1) begin
      failures++;
      $display("FAIL thr_old_red: got %b expected 1", mask);
    end
    send_pixel(16'h07E0);
    checks++;
    if (mask !== 1'b0) begin
      failures++;
      $display("FAIL thr_old_green: got %b expected 0", mask);
    end
    do_vsync(n);
    send_pixel(16'h07E0);
    checks++;
    if (mask !== 1'b1) begin
      failures++;
      $display("FAIL thr_new_green: got %b expected 1", mask);
    end
    send_pixel(16'hF800);
    checks++;
    if (mask !== 1'b0) begin
      failures++;
      $display("FAIL thr_new_red: got %b expected 0", mask);
    end
    do_vsync(n);
    checks++;
    if (n !== 1 || hit_cnt !== 1 || found !== 1'b1 ||
        {box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      failures++;
      $display("FAIL thr_new_stats: got valid=%0d cnt=%0d found=%b box=%0d,%0d,%0d,%0d expected 1 1 1 0,0,0,0",
               n, hit_cnt, found, box_xmin, box_xmax, box_ymin, box_ymax);
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    pre_frame_de = 1'b1;
    img_rgb = 24'h0007E0;
    repeat (5) tick();
    checks++;
    if (mask !== 1'b1 || post_frame_de !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stream: got mask=%b de=%b expected 1 1", mask, post_frame_de);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({post_frame_vsync, post_frame_hsync, post_frame_de, mask, stats_valid, found} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_flags: got %b expected 000000",
               {post_frame_vsync, post_frame_hsync, post_frame_de, mask, stats_valid, found});
    end
    checks++;
    if ({img_y, img_cb, img_cr} !== 24'h0) begin
      failures++;
      $display("FAIL midreset_pixel: got %h expected 000000", {img_y, img_cb, img_cr});
    end
    checks++;
    if ({hit_cnt, box_xmin, box_xmax, box_ymin, box_ymax} !== '0) begin
      failures++;
      $display("FAIL midreset_stats: got cnt=%0d box=%0d,%0d,%0d,%0d expected all 0",
               hit_cnt, box_xmin, box_xmax, box_ymin, box_ymax);
    end
    pre_frame_de = 1'b0;
    img_rgb = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_vsync(n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL post_reset_first_vsync: got %0d valid cycles expected 0", n);
    end
    do_vsync(n);
    checks++;
    if (n !== 1 || hit_cnt !== 0 || found !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_second_vsync: got valid=%0d cnt=%0d found=%b expected 1 0 0",
               n, hit_cnt, found);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_mask();
    test_stats();
    test_thr_midframe();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
